pc_redirect_unit: RTL and testbench
===================================

Name: pc_redirect_unit

Overview:
Fetch-side PC register and redirect sequencer, directly downstream of Branch_control. Consumes the resolved is_branch flag and branch target, and steers the program counter. Drives one-shot flush pulses to the IF/ID and ID/EX pipeline registers. Honours hazard-unit stalls by holding any redirect that arrives while the pipe is frozen.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
FLUSH_CYCLES, 2, number of cycles (>=1) after a redirect during which further is_branch requests are ignored.
CNT_W, 16, width of the saturating redirect counter.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
stall  input  1  hazard-unit freeze; PC holds while high.
is_branch  input  1  taken-branch/jump request from Branch_control, sampled each cycle.
branch_target  input  32  redirect target, valid when is_branch=1.
pc  output  32  current fetch PC (registered).
pc_valid  output  1  high from the first cycle after reset release.
flush_if  output  1  registered one-cycle pulse: squash the IF/ID register.
flush_id  output  1  registered one-cycle pulse: squash the ID/EX register.
misalign  output  1  registered one-cycle pulse: the request's target had [1:0]!=0.
busy  output  1  high in the HOLD or FLUSH state.
redirect_count  output  CNT_W  saturating count of accepted redirects.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. rst=1 at an edge, including mid-operation, forces:
  - pc=RESET_PC, pc_valid=0, flush_if=flush_id=misalign=0, busy=0;
  - redirect_count=0, pending target cleared, flush counter=0, state=RUN.
- pc_valid goes to 1 on the first edge with rst=0.
- States: RUN, HOLD, FLUSH.
- Request classification, sampled in RUN only:
  - A request is valid when is_branch=1 and branch_target[1:0]==2'b00.
  - A misaligned request (is_branch=1, target[1:0]!=0) sets misalign=1 for the next cycle only. No redirect occurs and no state change occurs. pc behaves as if no request was made.
- RUN, no request:
  - stall=0: pc<=pc+4, 32-bit wrap (32'hFFFF_FFFC -> 0).
  - stall=1: pc holds.
- RUN, valid request, stall=0:
  - Next cycle: pc=branch_target, flush_if=1, flush_id=1 (one cycle).
  - redirect_count increments, saturating at all-ones.
  - State -> FLUSH with counter=FLUSH_CYCLES-1. If FLUSH_CYCLES=1, state returns to RUN directly.
- RUN, valid request, stall=1:
  - Target latched into pending; pc holds; state -> HOLD; no flush yet.
- HOLD:
  - pc holds and is_branch is ignored; the first captured request wins.
  - When stall=0: pc<=pending, flush pulses, counter increments, enter FLUSH exactly as above.
- FLUSH:
  - is_branch and misalign detection are ignored; those requests come from squashed instructions.
  - stall=0: pc<=pc+4 and the counter decrements. At 0 the state -> RUN.
  - stall=1: pc and the counter both hold.
- busy=1 exactly while the state is HOLD or FLUSH.
- No combinational path from any input to any output.
- Redirect latency: 1 cycle from the request (or from stall release in HOLD) to the new pc.

Test Plan:
- Reset then run, RESET_PC=0, no requests -> cycles after release show pc=0,4,8,12; pc_valid=1 from the first cycle; flushes 0.
- At pc=0x10, is_branch=1 with target 0x100, stall=0 -> next cycle pc=0x100, flush_if=flush_id=1 for 1 cycle, redirect_count=1, busy=1 for 1 cycle (FLUSH_CYCLES=2). The following cycle pc=0x104.
- stall=1 for 3 cycles with is_branch=1 and target 0x200 in the first stall cycle, plus a second request with target 0x300 in the second -> pc frozen, busy=1. One cycle after stall drops: pc=0x200 with flush pulses; 0x300 is never taken.
- is_branch=1 with target 0x102 -> misalign=1 for one cycle, pc continues +4, redirect_count unchanged, no flush.
- Redirect to 0x40, then is_branch=1 with target 0x80 in the FLUSH cycle -> ignored; pc=0x44 then 0x48.
- Force pc to 0xFFFF_FFF8 via a redirect and run -> pc goes 0xFFFF_FFFC then 0x0. Assert rst during HOLD -> next cycle pc=RESET_PC, busy=0, pending discarded.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register plus redirect sequencer (RUN/HOLD/FLUSH).
// Ports: clk/rst (sync, active-high); stall, is_branch, branch_target in;
//        pc, pc_valid, flush_if, flush_id, misalign, busy, redirect_count out (all registered).
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             is_branch,
  input  logic [31:0]      branch_target,
  output logic [31:0]      pc,
  output logic             pc_valid,
  output logic             flush_if,
  output logic             flush_id,
  output logic             misalign,
  output logic             busy,
  output logic [CNT_W-1:0] redirect_count
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       pend_q, pend_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pc_valid_q, pc_valid_d;
  logic              flush_q, flush_d;
  logic              misalign_q, misalign_d;

  logic              req_ok;
  logic              req_bad;
  logic              redirect;
  logic [31:0]       redirect_pc;

  // Requests are only classified while in RUN; HOLD and FLUSH ignore is_branch.
  assign req_ok  = (state_q == ST_RUN) && is_branch && (branch_target[1:0] == 2'b00);
  assign req_bad = (state_q == ST_RUN) && is_branch && (branch_target[1:0] != 2'b00);

  // A redirect happens either straight from RUN or on stall release out of HOLD.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = branch_target;
    if (!stall) begin
      if (req_ok) begin
        redirect    = 1'b1;
        redirect_pc = branch_target;
      end else if (state_q == ST_HOLD) begin
        redirect    = 1'b1;
        redirect_pc = pend_q;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      state_d = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:   if (req_ok && stall) state_d = ST_HOLD;
        ST_HOLD:  state_d = ST_HOLD;
        ST_FLUSH: if (!stall && fcnt_q <= FW'(1)) state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // Datapath next values.
  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    fcnt_d     = fcnt_q;
    cnt_d      = cnt_q;
    pc_valid_d = 1'b1;
    flush_d    = 1'b0;
    misalign_d = req_bad;

    if (redirect) begin
      pc_d    = redirect_pc;
      flush_d = 1'b1;
      fcnt_d  = FW'(FLUSH_CYCLES - 1);
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
    end else if (state_q == ST_RUN && req_ok && stall) begin
      pend_d = branch_target;
    end else if (!stall && state_q != ST_HOLD) begin
      // RUN without a valid request, or FLUSH: sequential fetch with wrap.
      pc_d = pc_q + 32'd4;
      if (state_q == ST_FLUSH && fcnt_q != '0) fcnt_d = fcnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      fcnt_q     <= '0;
      cnt_q      <= '0;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      fcnt_q     <= fcnt_d;
      cnt_q      <= cnt_d;
      pc_valid_q <= pc_valid_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc             = pc_q;
  assign pc_valid       = pc_valid_q;
  assign flush_if       = flush_q;
  assign flush_id       = flush_q;
  assign misalign       = misalign_q;
  assign busy           = (state_q != ST_RUN);
  assign redirect_count = cnt_q;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed checks of the fetch PC / redirect sequencer.
// Ports: none; drives clk/rst/stall/is_branch/branch_target, samples 1 time unit after each rising edge.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        is_branch;
  logic [31:0] branch_target;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush_if;
  logic        flush_id;
  logic        misalign;
  logic        busy;
  logic [15:0] redirect_count;

  int checks = 0;
  int errors = 0;

  pc_redirect_unit #(
    .RESET_PC    (32'h0000_0000),
    .FLUSH_CYCLES(2),
    .CNT_W       (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .is_branch     (is_branch),
    .branch_target (branch_target),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .flush_if      (flush_if),
    .flush_id      (flush_id),
    .misalign      (misalign),
    .busy          (busy),
    .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks pc, busy, the two flushes, misalign and the redirect count in one go.
  task automatic expect_state(input string tag, input logic [31:0] e_pc, input logic e_busy,
                              input logic e_flush, input logic e_mis, input logic [15:0] e_cnt);
    check({tag, ".pc"},       pc,                     e_pc);
    check({tag, ".busy"},     {31'd0, busy},          {31'd0, e_busy});
    check({tag, ".flush_if"}, {31'd0, flush_if},      {31'd0, e_flush});
    check({tag, ".flush_id"}, {31'd0, flush_id},      {31'd0, e_flush});
    check({tag, ".misalign"}, {31'd0, misalign},      {31'd0, e_mis});
    check({tag, ".count"},    {16'd0, redirect_count}, {16'd0, e_cnt});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; is_branch = 1'b0; branch_target = '0;
    step();
    step();
    expect_state("reset", 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
    check("reset.pc_valid", {31'd0, pc_valid}, 32'd0);

    // Release reset: sequential fetch.
    rst = 1'b0;
    step();
    check("run0.pc_valid", {31'd0, pc_valid}, 32'd1);
    expect_state("run0", 32'h4, 1'b0, 1'b0, 1'b0, 16'd0);
    step(); check("run1.pc", pc, 32'h8);
    step(); check("run2.pc", pc, 32'hC);
    step(); check("run3.pc", pc, 32'h10);

    // Taken redirect from pc=0x10 to 0x100.
    is_branch = 1'b1; branch_target = 32'h100;
    step();
    expect_state("redir", 32'h100, 1'b1, 1'b1, 1'b0, 16'd1);
    is_branch = 1'b0;
    step();
    expect_state("redir+1", 32'h104, 1'b0, 1'b0, 1'b0, 16'd1);

    // Redirect during stall: first request (0x200) wins over 0x300.
    stall = 1'b1; is_branch = 1'b1; branch_target = 32'h200;
    step();
    expect_state("hold0", 32'h104, 1'b1, 1'b0, 1'b0, 16'd1);
    branch_target = 32'h300;
    step();
    expect_state("hold1", 32'h104, 1'b1, 1'b0, 1'b0, 16'd1);
    is_branch = 1'b0;
    step();
    expect_state("hold2", 32'h104, 1'b1, 1'b0, 1'b0, 16'd1);
    stall = 1'b0;
    step();
    expect_state("hold_rel", 32'h200, 1'b1, 1'b1, 1'b0, 16'd2);
    step();
    expect_state("hold_rel+1", 32'h204, 1'b0, 1'b0, 1'b0, 16'd2);

    // Misaligned target: one-cycle misalign pulse, no redirect.
    is_branch = 1'b1; branch_target = 32'h102;
    step();
    expect_state("misal", 32'h208, 1'b0, 1'b0, 1'b1, 16'd2);
    is_branch = 1'b0;
    step();
    expect_state("misal+1", 32'h20C, 1'b0, 1'b0, 1'b0, 16'd2);

    // Request during the FLUSH cycle is ignored.
    is_branch = 1'b1; branch_target = 32'h40;
    step();
    expect_state("r40", 32'h40, 1'b1, 1'b1, 1'b0, 16'd3);
    branch_target = 32'h80;
    step();
    expect_state("r40_ign", 32'h44, 1'b0, 1'b0, 1'b0, 16'd3);
    is_branch = 1'b0;
    step();
    check("r40_ign+1.pc", pc, 32'h48);

    // 32-bit wrap of the sequential PC.
    is_branch = 1'b1; branch_target = 32'hFFFF_FFF8;
    step();
    expect_state("wrap0", 32'hFFFF_FFF8, 1'b1, 1'b1, 1'b0, 16'd4);
    is_branch = 1'b0;
    step(); check("wrap1.pc", pc, 32'hFFFF_FFFC);
    step(); check("wrap2.pc", pc, 32'h0);
    step(); check("wrap3.pc", pc, 32'h4);

    // Reset asserted while in HOLD discards the pending target.
    stall = 1'b1; is_branch = 1'b1; branch_target = 32'h500;
    step();
    expect_state("hold_rst0", 32'h4, 1'b1, 1'b0, 1'b0, 16'd4);
    rst = 1'b1; stall = 1'b0; is_branch = 1'b0;
    step();
    expect_state("hold_rst", 32'h0, 1'b0, 1'b0, 1'b0, 16'd0);
    check("hold_rst.pc_valid", {31'd0, pc_valid}, 32'd0);
    rst = 1'b0;
    step();
    expect_state("post_rst", 32'h4, 1'b0, 1'b0, 1'b0, 16'd0);
    check("post_rst.pc_valid", {31'd0, pc_valid}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
